// File: rtl/router_1xn.sv
// router_1xn: 1-to-N packet router with parity check, busy backpressure and per-port timeout flush
module router_fifo #(
   parameter int DW      = 8,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 30
) (
   input  logic          clock,
   input  logic          rst,
   input  logic          push,
   input  logic          read_enb,
   input  logic [DW-1:0] din,
   output logic          full,
   output logic          vld_out,
   output logic [DW-1:0] dout
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] idle;
   logic          pop, flush;

   assign vld_out = count != '0;
   assign full    = count == CW'(DEPTH);
   assign pop     = read_enb && vld_out;
   assign flush   = vld_out && !read_enb && idle == TW'(TIMEOUT - 1);
   assign dout    = vld_out ? mem[rd_ptr] : '0;

   always_ff @(posedge clock)
      if (push && !flush) mem[wr_ptr] <= din;

   // a flush drops any same-edge push along with the stored words
   always_ff @(posedge clock)
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         idle   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
         idle  <= (pop || !vld_out) ? '0 : idle + TW'(1);
      end
endmodule

module router_1xn #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PORTS  = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 30
) (
   input  logic                             clock,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             pkt_valid,
   output logic                             busy,
   output logic                             error,
   input  logic [NUM_PORTS-1:0]             read_enb,
   output logic [NUM_PORTS-1:0]             vld_out,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  data_out
);
   localparam int ADDR_W = $clog2(NUM_PORTS);
   localparam int LEN_W  = DATA_WIDTH - ADDR_W;

   typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, CHECK} state_t;

   state_t                 state;
   logic [ADDR_W-1:0]      dest, port;
   logic [LEN_W-1:0]       remain;
   logic [DATA_WIDTH-1:0]  acc;
   logic [NUM_PORTS-1:0]   full;
   logic                   accept;

   // in IDLE the header itself selects the target FIFO
   always_comb begin
      port   = state == IDLE ? data_in[ADDR_W-1:0] : dest;
      busy   = rst || state == CHECK || (full[port] && (pkt_valid || state != IDLE));
      accept = pkt_valid && !busy;
   end

   always_ff @(posedge clock)
      if (rst) begin
         state  <= IDLE;
         dest   <= '0;
         remain <= '0;
         acc    <= '0;
         error  <= 1'b0;
      end else begin
         error <= 1'b0;
         case (state)
            IDLE:
               if (accept) begin
                  dest   <= data_in[ADDR_W-1:0];
                  remain <= data_in[DATA_WIDTH-1:ADDR_W];
                  acc    <= data_in;
                  state  <= (data_in[DATA_WIDTH-1:ADDR_W] != '0) ? PAYLOAD : PARITY;
               end
            PAYLOAD:
               if (accept) begin
                  acc    <= acc ^ data_in;
                  remain <= remain - LEN_W'(1);
                  if (remain == LEN_W'(1)) state <= PARITY;
               end
            PARITY:
               if (accept) begin
                  error <= data_in != acc;
                  state <= CHECK;
               end
            default: state <= IDLE;
         endcase
      end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      router_fifo #(
         .DW      (DATA_WIDTH),
         .DEPTH   (FIFO_DEPTH),
         .TIMEOUT (TIMEOUT)
      ) u_fifo (
         .clock    (clock),
         .rst      (rst),
         .push     (accept && port == ADDR_W'(i)),
         .read_enb (read_enb[i]),
         .din      (data_in),
         .full     (full[i]),
         .vld_out  (vld_out[i]),
         .dout     (data_out[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end
endmodule
